fifo_pop_reader: RTL and testbench
==================================

Name: fifo_pop_reader

Overview:
- Pop-side reader for the dual-clock FIFO; sits entirely in the clk_pop domain.
- Drives the FIFO pop interface (pop_req_n, data_out, pop_empty, pop_error) and re-presents the words as a valid/ready stream to a downstream consumer.
- Holds a 2-entry output skid buffer so that pop_req_n never depends combinationally on out_ready.
- Also tracks FIFO pop-side errors and, optionally, counts popped words.

Parameters:
DATA_WIDTH, 32, width of FIFO data_out and of out_data.
CNT_WIDTH, 16, width of the popped-word counter (optional feature only).

Ports:
clk_pop  input  1  pop-domain clock; all logic is on its rising edge.
rst_n  input  1  asynchronous active-low reset.
rd_en  input  1  1 = reader may issue pops; 0 = no new pops, buffer still drains.
flush  input  1  synchronous discard of buffered words, active-high, single cycle.
pop_req_n  output  1  FIFO pop request, active-low.
data_out  input  DATA_WIDTH  FIFO head word; valid whenever pop_empty=0.
pop_empty  input  1  FIFO empty flag, pop domain.
pop_error  input  1  FIFO pop-side error flag.
out_valid  output  1  downstream word valid.
out_data  output  DATA_WIDTH  downstream word.
out_ready  input  1  downstream accept.
err_sticky  output  1  latched pop_error.
err_clr  input  1  clears err_sticky.
rd_count  output  CNT_WIDTH  popped-word count (optional feature).

Behaviour:
- Reset (rst_n=0, asynchronous): buffer occupancy occ=0, out_valid=0, out_data=0, err_sticky=0, rd_count=0, entries cleared.
- pop_req_n is combinational only from registered occ and these inputs: pop_req_n = ~(rd_en & ~pop_empty & ~flush & (occ<2)).
  - pop_req_n is 1 during reset.
- Pop fire: pop_req_n=0 at a clk_pop edge. data_out is captured into the buffer at that same edge. The FIFO advances its head at that edge.
- Buffer: 2-entry FIFO (head entry, skid entry); occ is 0, 1 or 2.
  - out_valid = (occ!=0).
  - out_data = head entry (registered).
- Accept: out_valid & out_ready at an edge.
- Occupancy update, where pop = pop fire and acc = accept:
  - pop & ~acc: occ+1, word goes to the first free slot.
  - acc & ~pop: occ-1, skid entry moves to head.
  - pop & acc: occ unchanged. At occ=1 the new word lands in head. At occ=2 skid moves to head and the new word goes to skid.
  - occ never exceeds 2, because a pop is impossible at occ=2.
- Latency: FIFO head available with occ=0 -> pop on edge N -> out_valid=1 after edge N (1 cycle).
- Throughput: 1 word/cycle sustained while out_ready=1 and the FIFO is non-empty.
- Back-pressure: out_ready=0 stalls pops once occ=2. out_valid/out_data are held stable until accepted.
- flush=1: no pop that cycle (pop_req_n=1). At the edge occ->0 and out_valid->0. Accept in the same cycle is ignored. Flush has priority over everything else except reset.
- rd_en=0: no pops; buffered words continue to drain via out_ready.
- pop_empty rising while occ<2: pop_req_n deasserts in the same cycle, so no pop is issued into an empty FIFO.
- Errors:
  - err_sticky set at any edge with pop_error=1.
  - err_clr clears it.
  - Simultaneous set and clear: set wins.
- Reset mid-operation: immediate return to reset values. Buffered words are lost; no partial pop is issued.

Optional Feature:
- Macro: FIFO_POP_READER_CNT_EN.
- Defined: rd_count increments by 1 on every pop fire and wraps modulo 2^CNT_WIDTH. flush does not clear it; only rst_n clears it.
- Undefined: no counter logic is built and rd_count is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33, rd_en=1, out_ready=1 -> pop_req_n low 3 consecutive cycles; out_data 0x11,0x22,0x33 on consecutive cycles, each valid one cycle after its pop; pop_req_n high once pop_empty=1.
- 5 words queued, out_ready=0 -> exactly 2 pops, occ=2, out_data=first word held; out_ready=1 -> remaining 3 popped and all 5 delivered in order, no loss or duplicate.
- occ=2 with flush=1 for one cycle -> out_valid=0 next cycle, no pop that cycle; subsequent pops resume with the next FIFO word.
- pop_error pulsed one cycle -> err_sticky=1 and held. err_clr and pop_error asserted together -> err_sticky stays 1. err_clr alone -> err_sticky 0.
- With FIFO_POP_READER_CNT_EN, CNT_WIDTH=4: 18 pops -> rd_count=2 (wrap). Without the macro, rd_count stays 0 throughout.
- rst_n asserted asynchronously mid-stream with occ=2 -> out_valid, occ, err_sticky and rd_count at 0 immediately; pop_req_n=1 until reset is released.

Source files
------------

// File: rtl/fifo_pop_reader.sv
// Pop-side reader for the dual-clock FIFO: pops into a 2-entry skid buffer, streams valid/ready.
// Optional popped-word counter enabled by FIFO_POP_READER_CNT_EN.
module fifo_pop_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_pop,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic                  pop_req_n,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  pop_empty,
  input  logic                  pop_error,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  err_sticky,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  r_err;
  logic                  w_pop;
  logic                  w_acc;

  // rst_n gates the request so nothing is popped while reset is held
  assign w_pop = rst_n & rd_en & ~pop_empty & ~flush
               & (r_occ != 2'd2);
  assign w_acc = (r_occ != 2'd0) & out_ready & ~flush;

  assign pop_req_n  = ~w_pop;
  assign out_valid  = (r_occ != 2'd0);
  assign out_data   = r_head;
  assign err_sticky = r_err;

  always_ff @(posedge clk_pop or negedge rst_n) begin
    if (!rst_n) begin
      r_occ  <= 2'd0;
      r_head <= '0;
      r_skid <= '0;
    end else if (flush) begin
      r_occ <= 2'd0;
    end else begin
      unique case (1'b1)
        (w_pop & ~w_acc): begin
          r_occ <= r_occ + 2'd1;
          if (r_occ == 2'd0) r_head <= data_out;
          else               r_skid <= data_out;
        end
        (w_acc & ~w_pop): begin
          r_occ  <= r_occ - 2'd1;
          r_head <= r_skid;
        end
        (w_pop & w_acc): begin
          if (r_occ == 2'd1) begin
            r_head <= data_out;
          end else begin
            r_head <= r_skid;
            r_skid <= data_out;
          end
        end
        default: ;
      endcase
    end
  end

  // set beats clear when both arrive together
  always_ff @(posedge clk_pop or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (pop_error) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

`ifdef FIFO_POP_READER_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_pop or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (w_pop) r_cnt <= r_cnt + CNT_WIDTH'(1);
  end

  assign rd_count = r_cnt;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_pop_reader.sv
// Directed bench for fifo_pop_reader with a simple FIFO head model.
// Counter checks follow FIFO_POP_READER_CNT_EN.
module tb_fifo_pop_reader;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk_pop = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic          flush;
  logic          pop_req_n;
  logic [DW-1:0] data_out;
  logic          pop_empty;
  logic          pop_error;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          err_sticky;
  logic          err_clr;
  logic [CW-1:0] rd_count;

  fifo_pop_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_pop    (clk_pop),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .flush      (flush),
    .pop_req_n  (pop_req_n),
    .data_out   (data_out),
    .pop_empty  (pop_empty),
    .pop_error  (pop_error),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .rd_count   (rd_count)
  );

  always #5 clk_pop = ~clk_pop;

  logic [DW-1:0] mem [0:127];
  int unsigned   wr_ptr = 0;
  int unsigned   rd_ptr = 0;
  int unsigned   pops   = 0;
  logic [DW-1:0] got [$];

  assign pop_empty = (wr_ptr == rd_ptr);
  assign data_out  = mem[rd_ptr[6:0]];

  always @(posedge clk_pop) begin
    if (!pop_req_n) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
    if (rst_n && out_valid && out_ready && !flush)
      got.push_back(out_data);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr[6:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_pop);
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int c = 0; c < budget && got.size() < n; c++)
      @(negedge clk_pop);
    chk("wait_got", 64'(got.size()), 64'(n));
  endtask

  typedef struct {
    logic perr;
    logic eclr;
    logic exp_err;
  } err_vec_t;

  typedef struct {
    logic rd_en;
    logic flush;
    logic exp_req_n;
  } req_vec_t;

  err_vec_t ev [6];
  req_vec_t rv [4];
  int unsigned p0;
  logic [CW-1:0] exp_cnt;

  initial begin
    ev[0] = '{1'b1, 1'b0, 1'b1};
    ev[1] = '{1'b0, 1'b0, 1'b1};
    ev[2] = '{1'b1, 1'b1, 1'b1};
    ev[3] = '{1'b0, 1'b1, 1'b0};
    ev[4] = '{1'b0, 1'b0, 1'b0};
    ev[5] = '{1'b0, 1'b1, 1'b0};
    rv[0] = '{1'b0, 1'b0, 1'b1};
    rv[1] = '{1'b1, 1'b1, 1'b1};
    rv[2] = '{1'b0, 1'b1, 1'b1};
    rv[3] = '{1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; rd_en = 1'b1; flush = 1'b0;
    pop_error = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    push(32'h11); push(32'h22); push(32'h33);
    cyc(3);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_err", 64'(err_sticky), 0);
    chk("rst_cnt", 64'(rd_count), 0);
    chk("rst_req_n", 64'(pop_req_n), 1);
    chk("rst_nopop", 64'(pops), 0);

    // streaming: one word per cycle, each valid one cycle after its pop
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("s1_req_n", 64'(pop_req_n), 0);
      cyc(1);
      chk("s1_valid", 64'(out_valid), 1);
      chk("s1_data", 64'(out_data), 64'(32'h11 * (i + 1)));
    end
    chk("s1_empty_req_n", 64'(pop_req_n), 1);
    cyc(1);
    chk("s1_drained", 64'(out_valid), 0);
    chk("s1_pops", 64'(pops), 3);
    chk("s1_got_n", 64'(got.size()), 3);
    for (int i = 0; i < 3; i++)
      chk("s1_got", 64'(got[i]), 64'(32'h11 * (i + 1)));
    got.delete();

    // back-pressure: two pops then stall, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'hA1 + i);
    p0 = pops;
    cyc(4);
    chk("bp_pops", 64'(pops - p0), 2);
    chk("bp_valid", 64'(out_valid), 1);
    chk("bp_hold", 64'(out_data), 64'h0A1);
    chk("bp_req_n", 64'(pop_req_n), 1);
    out_ready = 1'b1;
    wait_got(5, 20);
    for (int i = 0; i < 5; i++)
      chk("bp_order", 64'(got[i]), 64'(32'hA1 + i));
    cyc(1);
    chk("bp_pops_all", 64'(pops - p0), 5);
    chk("bp_ngot", 64'(got.size()), 5);
    got.delete();

    // flush at occ=2, with a same-cycle accept that must be ignored
    out_ready = 1'b0;
    push(32'hB1); push(32'hB2); push(32'hB3);
    p0 = pops;
    cyc(3);
    chk("fl_pre_pops", 64'(pops - p0), 2);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_req_n", 64'(pop_req_n), 1);
    cyc(1);
    flush = 1'b0;
    chk("fl_valid", 64'(out_valid), 0);
    chk("fl_pops", 64'(pops - p0), 2);
    chk("fl_noacc", 64'(got.size()), 0);
    #1;
    chk("fl_resume_req", 64'(pop_req_n), 0);
    cyc(1);
    chk("fl_resume_v", 64'(out_valid), 1);
    chk("fl_resume_d", 64'(out_data), 64'h0B3);
    cyc(1);
    chk("fl_got_b3", 64'(got[0]), 64'h0B3);
    chk("fl_empty", 64'(out_valid), 0);
    got.delete();

    // pop request decode with one word waiting and occ=0
    rd_en = 1'b0;
    push(32'hC1);
    for (int i = 0; i < 4; i++) begin
      rd_en = rv[i].rd_en;
      flush = rv[i].flush;
      #1;
      chk("req_tbl", 64'(pop_req_n), 64'(rv[i].exp_req_n));
    end
    rd_en = 1'b1; flush = 1'b0;
    cyc(2);
    chk("req_c1", 64'(got[0]), 64'h0C1);
    got.delete();

    for (int i = 0; i < 6; i++) begin
      pop_error = ev[i].perr;
      err_clr   = ev[i].eclr;
      cyc(1);
      chk("err_tbl", 64'(err_sticky), 64'(ev[i].exp_err));
    end
    pop_error = 1'b0; err_clr = 1'b0;

    // asynchronous reset with two words buffered
    out_ready = 1'b0;
    push(32'hD1); push(32'hD2); push(32'hD3);
    pop_error = 1'b1;
    cyc(1);
    pop_error = 1'b0;
    cyc(2);
    chk("ar_pre_v", 64'(out_valid), 1);
    chk("ar_pre_err", 64'(err_sticky), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 0);
    chk("ar_data", 64'(out_data), 0);
    chk("ar_err", 64'(err_sticky), 0);
    chk("ar_cnt", 64'(rd_count), 0);
    chk("ar_req_n", 64'(pop_req_n), 1);
    p0 = pops;
    cyc(2);
    chk("ar_nopop", 64'(pops - p0), 0);
    got.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    wait_got(1, 10);
    cyc(2);
    chk("ar_left_n", 64'(got.size()), 1);
    chk("ar_left_d", 64'(got[0]), 64'h0D3);
    got.delete();

    // 18 pops from a clean reset: a 4-bit counter wraps to 2
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) push(32'h100 + i);
    wait_got(18, 40);
    chk("cnt_last", 64'(got[17]), 64'h111);
`ifdef FIFO_POP_READER_CNT_EN
    exp_cnt = 4'd2;
`else
    exp_cnt = 4'd0;
`endif
    chk("cnt_wrap", 64'(rd_count), 64'(exp_cnt));
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("cnt_flush", 64'(rd_count), 64'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
